// File: rtl/reg_array_reader.sv
// Snapshot-and-stream reader for the FFT register array: captures N words on start and
// emits them over valid/ready. Define REG_ARRAY_READER_BITREV_EN for bit-reversed order.
module reg_array_reader #(
  parameter int N   = 32,
  parameter int MSB = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N*MSB-1:0]     data_in,
  output logic [MSB-1:0]       out_data,
  output logic [$clog2(N)-1:0] out_index,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam int IW = $clog2(N);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  cnt_q, cnt_d;
  logic           done_q, done_d;
  logic           capture;
  logic           last_word;
  logic [IW-1:0]  ord_idx;
  logic [MSB-1:0] snap_q [N];
  logic [MSB-1:0] snap_d [N];

  // cnt counts transfers, so out_last marks the N-th word regardless of ordering
  assign last_word = (cnt_q == IW'(N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (last_word) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Snapshot decouples the stream from later writes into the array
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_snap
      assign snap_d[gi] = capture ? data_in[gi*MSB +: MSB] : snap_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) snap_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) snap_q[i] <= snap_d[i];
    end
  end

`ifdef REG_ARRAY_READER_BITREV_EN
  generate
    for (gi = 0; gi < IW; gi++) begin : g_bitrev
      assign ord_idx[gi] = cnt_q[IW-1-gi];
    end
  endgenerate
`else
  assign ord_idx = cnt_q;
`endif

  // Outputs decode only registered state; forced to zero outside a frame
  assign busy      = (state_q == STREAM);
  assign out_valid = busy;
  assign out_index = busy ? ord_idx : '0;
  assign out_data  = busy ? snap_q[ord_idx] : '0;
  assign out_last  = busy & last_word;
  assign done      = done_q;

endmodule

// File: doc/reg_array_reader.md
# reg_array_reader

Read-side companion to the FFT stage's register array. It snapshots the flattened N-word bus that the array exposes and streams the words out one per cycle over a valid/ready handshake, in natural or bit-reversed index order. It sits between the register array and the serial consumer: the butterfly datapath or the output UART. Because of the snapshot, the writer may refill the array while a frame is still streaming.

## Interface
Parameters:
- N, default 32: number of words; must be a power of two, N ≥ 2.
- MSB, default 16: word width in bits.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: request to capture `data_in` and stream one frame.
- data_in, input, N*MSB: flattened words; word i is at bits [(i+1)*MSB-1 : i*MSB].
- out_data, output, MSB: current word.
- out_index, output, $clog2(N): array index of the current word.
- out_valid, output, 1: `out_data`, `out_index` and `out_last` are valid.
- out_ready, input, 1: consumer accepts the word.
- out_last, output, 1: current word is the final word of the frame.
- busy, output, 1: a frame is in progress.
- done, output, 1: one-cycle pulse after the final word is accepted.

## Operation
- There are two states, IDLE and STREAM.
- IDLE:
  - `busy`=0 and `out_valid`=0.
  - If `start`=1 at a rising edge: latch all of `data_in` into an internal snapshot, clear the sequence counter `cnt` to 0, and go to STREAM.
- STREAM:
  - `busy`=1 and `out_valid`=1.
  - `out_index` = ord(cnt), where ord() is the identity, or bit-reversal of the $clog2(N)-bit value (see Configuration).
  - `out_data` = snapshot[ord(cnt)].
  - `out_last` = (cnt == N-1).
- Handshake:
  - A word transfers on a rising edge where `out_valid` & `out_ready`.
  - On a transfer with cnt < N-1: cnt increments.
  - On a transfer with cnt == N-1: go to IDLE, with `done`=1 in the following cycle.
- Stall: while `out_valid`=1 and `out_ready`=0, all outputs hold stable.
- `start` in STREAM is ignored; it is neither queued nor restarted.
- `start` in the cycle where `done`=1 is legal. The state is already IDLE, so the frame restarts back-to-back.
- Changes on `data_in` after the capture edge do not affect the frame in flight.
- cnt never wraps: it is cleared only on capture.

## Timing
- Reset values: `out_data`=0, `out_index`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0; state IDLE; snapshot all zeros; cnt=0.
- Reset asserted mid-frame aborts the frame immediately and asynchronously. No `done` pulse is produced.
- Latency: if `start` is sampled at edge k, the first word is valid in the cycle after edge k.
- Throughput: one word per cycle with `out_ready` held high, so a frame takes N cycles.
- Minimum period: start-to-start is N+1 cycles, i.e. N words plus one IDLE/`done` cycle.
- `done` is high for exactly one cycle: the cycle after the edge that accepted the last word.
- `data_in` is sampled on the rising edge. A register-array write made on the preceding falling edge is included in the snapshot.
- All outputs are registered or decoded only from registered state. There is no combinational path from `out_ready` or `start` to any output.

## Configuration
- Macro: `REG_ARRAY_READER_BITREV_EN`.
- Defined: ord(cnt) is cnt with its $clog2(N) bits reversed. Words emerge in bit-reversed order, as needed to feed the FFT input.
- Undefined: ord(cnt) = cnt, giving natural order 0..N-1.
- Handshake, latency and `out_last`/`done` behaviour are identical in both builds. `out_last` always marks the N-th transfer, not index N-1.

## Test plan
- N=4, MSB=16, natural order:
  - Stimulus: `data_in` = {16'h0004, 16'h0003, 16'h0002, 16'h0001}; pulse `start`; `out_ready`=1.
  - Required: `out_data` 1,2,3,4 on consecutive cycles; `out_index` 0..3; `out_last` only on 4; `done` 1 cycle later; `busy` falls with `done`.
- Same stimulus, built with `REG_ARRAY_READER_BITREV_EN`:
  - Required: `out_index` 0,2,1,3 and `out_data` 1,3,2,4; `out_last` on the 4th word.
- Backpressure:
  - Stimulus: drop `out_ready` for 3 cycles while word 2 is shown.
  - Required: `out_data`/`out_index`/`out_valid` hold for those cycles; the frame still ends with 4 transfers and one `done`.
- Snapshot isolation:
  - Stimulus: change `data_in` to all 16'hFFFF one cycle after `start`.
  - Required: the streamed words are still 1,2,3,4.
- `start` behaviour:
  - `start` pulsed mid-frame: ignored, with no extra words.
  - `start` in the `done` cycle: a new frame begins the next cycle with `out_valid`=1.
- Reset mid-frame:
  - Stimulus: assert `rst` between clock edges after word 1.
  - Required: all outputs go to 0 immediately, with no `done`. After release, a new `start` streams a full frame.
